// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - PLL lock qualifier, core reset sequencer and divided clock-enable generator
module cpu_clk_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 16,
    parameter int LOCK_CYCLES = 16,
    parameter int DIV_RST     = 0,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LCNT_W     = $clog2(LOCK_CYCLES + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              locked,
    input  logic [1:0]        mode,
    input  logic              step_req,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              core_rst_n,
    output logic [NUM_CH-1:0] ce,
    output logic [LCNT_W-1:0] lock_cnt
);

    localparam logic [DIV_W-1:0]  DIV_INIT  = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0]  CNT_ONE   = DIV_W'(1);
    localparam logic [LCNT_W-1:0] LOCK_MAX  = LCNT_W'(LOCK_CYCLES);
    localparam logic [LCNT_W-1:0] LCNT_ONE  = LCNT_W'(1);
    localparam logic [1:0]        MODE_RUN  = 2'b00;
    localparam logic [1:0]        MODE_STEP = 2'b10;

    typedef enum logic {
        ST_WAIT_LOCK,
        ST_ACTIVE
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q [NUM_CH];
    logic [DIV_W-1:0] cnt_q [NUM_CH];

    logic              run_mode;
    logic              step_mode;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] term_hit;

    // Mode 11 falls out as HALT: neither run nor step.
    always_comb begin
        run_mode  = (mode == MODE_RUN);
        step_mode = (mode == MODE_STEP);
        wr_hit    = '0;
        term_hit  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_hit[i]   = cfg_we && (cfg_ch == CH_W'(i));
            term_hit[i] = (cnt_q[i] == div_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_WAIT_LOCK;
            core_rst_n <= 1'b0;
            ce         <= '0;
            lock_cnt   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
                div_q[i] <= DIV_INIT;
            end
        end else begin
            // Divide registers take writes in every state, even during lock loss.
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_hit[i]) begin
                    div_q[i] <= cfg_div;
                end
            end

            if (!locked) begin
                state      <= ST_WAIT_LOCK;
                core_rst_n <= 1'b0;
                ce         <= '0;
                lock_cnt   <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_q[i] <= '0;
                end
            end else if (state == ST_WAIT_LOCK) begin
                ce <= '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    cnt_q[i] <= '0;
                end
                if (lock_cnt == LOCK_MAX) begin
                    state      <= ST_ACTIVE;
                    core_rst_n <= 1'b1;
                end else begin
                    lock_cnt <= lock_cnt + LCNT_ONE;
                end
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (wr_hit[i]) begin
                        cnt_q[i] <= '0;
                    end else if (run_mode && term_hit[i]) begin
                        cnt_q[i] <= '0;
                    end else if (run_mode) begin
                        cnt_q[i] <= cnt_q[i] + CNT_ONE;
                    end
                    // A step pulse ignores the divider and survives a same-cycle write.
                    if (step_mode) begin
                        ce[i] <= step_req;
                    end else begin
                        ce[i] <= run_mode && term_hit[i] && !wr_hit[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// tb/tb_cpu_clk_ctrl.sv - randomized self-checking bench for cpu_clk_ctrl
module tb_cpu_clk_ctrl;

    localparam int NUM_CH      = 5;
    localparam int DIV_W       = 16;
    localparam int LOCK_CYCLES = 16;
    localparam int DIV_RST     = 2;
    localparam int CH_W        = 3;
    localparam int LCNT_W      = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              locked = 1'b0;
    logic [1:0]        mode = 2'b00;
    logic              step_req = 1'b0;
    logic              cfg_we = 1'b0;
    logic [CH_W-1:0]   cfg_ch = '0;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              core_rst_n;
    logic [NUM_CH-1:0] ce;
    logic [LCNT_W-1:0] lock_cnt;

    cpu_clk_ctrl #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK_CYCLES), .DIV_RST(DIV_RST)
    ) dut (
        .clk(clk), .rst_n(rst_n), .locked(locked), .mode(mode), .step_req(step_req),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .core_rst_n(core_rst_n), .ce(ce), .lock_cnt(lock_cnt)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // Reference model: consecutive-locked streak, per-channel elapsed run cycles and divide values.
    int                streak = 0;
    int                t_run [NUM_CH];
    int                mdiv [NUM_CH];
    logic [NUM_CH-1:0] m_ce = '0;
    logic              m_core = 1'b0;
    logic [LCNT_W-1:0] m_lock = '0;

    task automatic tick();
        bit act;
        bit wr;
        @(posedge clk);
        if (!rst_n) begin
            streak = 0;
            m_ce = '0;
            for (int i = 0; i < NUM_CH; i++) begin
                t_run[i] = 0;
                mdiv[i] = DIV_RST;
            end
        end else begin
            act = (streak > LOCK_CYCLES);
            for (int i = 0; i < NUM_CH; i++) begin
                wr = cfg_we && (int'(cfg_ch) == i);
                if (!locked || !act) begin
                    m_ce[i] = 1'b0;
                    t_run[i] = 0;
                end else if (mode == 2'b00) begin
                    if (wr) begin
                        m_ce[i] = 1'b0;
                        t_run[i] = 0;
                    end else begin
                        m_ce[i] = ((t_run[i] % (mdiv[i] + 1)) == mdiv[i]);
                        t_run[i]++;
                    end
                end else begin
                    m_ce[i] = (mode == 2'b10) && step_req;
                    if (wr) t_run[i] = 0;
                end
                if (wr) mdiv[i] = int'(cfg_div);
            end
            if (!locked) streak = 0;
            else if (streak <= LOCK_CYCLES) streak++;
        end
        m_lock = LCNT_W'((streak < LOCK_CYCLES) ? streak : LOCK_CYCLES);
        m_core = (streak > LOCK_CYCLES);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; locked = 1'b1; mode = 2'b10; step_req = 1'b1;
        cfg_we = 1'b1; cfg_ch = 3'd0; cfg_div = 16'd5;
        for (int k = 0; k < 3; k++) begin
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {1'b0, {LCNT_W{1'b0}}, {NUM_CH{1'b0}}})
                $display("FAIL reset_state: got core=%b lock_cnt=%0d ce=%b want all zero", core_rst_n, lock_cnt, ce);
            else pass_cnt++;
        end
        rst_n = 1'b1; locked = 1'b0; mode = 2'b00; step_req = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic test_lock();
        int n;
        for (int k = 0; k < 2; k++) begin
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL lock_idle: got core=%b lock_cnt=%0d ce=%b want core=%b lock_cnt=%0d ce=%b", core_rst_n, lock_cnt, ce, m_core, m_lock, m_ce);
            else pass_cnt++;
        end
        locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL lock_qualify: got core=%b lock_cnt=%0d ce=%b want core=%b lock_cnt=%0d ce=%b", core_rst_n, lock_cnt, ce, m_core, m_lock, m_ce);
            else pass_cnt++;
            if (n <= LOCK_CYCLES) begin
                total_cnt++;
                if (lock_cnt !== LCNT_W'(n) || core_rst_n !== 1'b0 || ce !== '0)
                    $display("FAIL lock_count_seq: got lock_cnt=%0d core=%b ce=%b want lock_cnt=%0d core=0 ce=0", lock_cnt, core_rst_n, ce, n);
                else pass_cnt++;
            end
        end while (core_rst_n !== 1'b1 && n < 40);
        total_cnt++;
        if (n - 1 != LOCK_CYCLES)
            $display("FAIL lock_release_latency: got %0d edges want %0d", n - 1, LOCK_CYCLES);
        else pass_cnt++;
    endtask

    task automatic test_glitch();
        int n;
        for (int k = 0; k < 5; k++) tick();
        locked = 1'b0;
        tick();
        total_cnt++;
        if (core_rst_n !== 1'b0 || ce !== '0 || lock_cnt !== '0)
            $display("FAIL active_drop: got core=%b ce=%b lock_cnt=%0d want 0 0 0", core_rst_n, ce, lock_cnt);
        else pass_cnt++;
        locked = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL glitch_count: got core=%b lock_cnt=%0d ce=%b want core=%b lock_cnt=%0d ce=%b", core_rst_n, lock_cnt, ce, m_core, m_lock, m_ce);
            else pass_cnt++;
        end
        total_cnt++;
        if (lock_cnt !== LCNT_W'(10)) $display("FAIL glitch_pre: got lock_cnt=%0d want 10", lock_cnt);
        else pass_cnt++;
        locked = 1'b0;
        tick();
        total_cnt++;
        if (lock_cnt !== '0 || core_rst_n !== 1'b0) $display("FAIL glitch_clear: got lock_cnt=%0d core=%b want 0 0", lock_cnt, core_rst_n);
        else pass_cnt++;
        locked = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL glitch_requal: got core=%b lock_cnt=%0d ce=%b want core=%b lock_cnt=%0d ce=%b", core_rst_n, lock_cnt, ce, m_core, m_lock, m_ce);
            else pass_cnt++;
        end while (core_rst_n !== 1'b1 && n < 40);
        total_cnt++;
        if (n != LOCK_CYCLES + 1) $display("FAIL glitch_release: got %0d cycles want %0d", n, LOCK_CYCLES + 1);
        else pass_cnt++;
    endtask

    task automatic test_dividers();
        int cnt [4];
        int divs [4] = '{0, 1, 3, 9};
        int want [4] = '{40, 20, 10, 4};
        mode = 2'b00;
        for (int c = 0; c < 4; c++) begin
            cfg_we = 1'b1; cfg_ch = CH_W'(c); cfg_div = DIV_W'(divs[c]);
            tick();
        end
        cfg_we = 1'b0;
        for (int k = 0; k < $urandom_range(0, 9); k++) tick();
        for (int c = 0; c < 4; c++) cnt[c] = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int c = 0; c < 4; c++) cnt[c] += int'(ce[c]);
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL div_run: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
        for (int c = 0; c < 4; c++) begin
            total_cnt++;
            if (cnt[c] != want[c]) $display("FAIL div_count ch%0d: got %0d pulses want %0d", c, cnt[c], want[c]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reconfig();
        int n;
        int pulses;
        for (int k = 0; k < $urandom_range(1, 7); k++) tick();
        cfg_we = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd7;
        tick();
        cfg_we = 1'b0;
        total_cnt++;
        if (ce[2] !== 1'b0) $display("FAIL reconfig_write_cycle: got ce2=%b want 0", ce[2]);
        else pass_cnt++;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                tick();
                n++;
                total_cnt++;
                if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                    $display("FAIL reconfig_run: got ce=%b want ce=%b", ce, m_ce);
                else pass_cnt++;
            end while (ce[2] !== 1'b1 && n < 20);
            total_cnt++;
            if (n != 8) $display("FAIL reconfig_period%0d: got %0d cycles want 8", r, n);
            else pass_cnt++;
        end
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            cfg_we = (k < 3); cfg_ch = CH_W'(NUM_CH + (k % 3)); cfg_div = 16'd0;
            tick();
            pulses += int'(ce[2]);
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL bad_ch_write: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
        cfg_we = 1'b0;
        total_cnt++;
        if (pulses != 2) $display("FAIL bad_ch_effect: got %0d ch2 pulses want 2", pulses);
        else pass_cnt++;
    endtask

    task automatic test_halt_step();
        int steps;
        for (int k = 0; k < $urandom_range(3, 9); k++) tick();
        mode = 2'b01;
        for (int k = 0; k < 6; k++) begin
            tick();
            total_cnt++;
            if (ce !== '0) $display("FAIL halt_ce: got ce=%b want 0", ce);
            else pass_cnt++;
        end
        mode = 2'b11; step_req = 1'b1;
        tick();
        step_req = 1'b0;
        total_cnt++;
        if (ce !== '0) $display("FAIL halt_step_ignored: got ce=%b want 0", ce);
        else pass_cnt++;
        mode = 2'b10;
        steps = 0;
        for (int k = 0; k < 8; k++) begin
            step_req = (k == 1 || k == 4 || k == 6);
            tick();
            if (ce === '1) steps++;
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL step_ce: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
        step_req = 1'b0;
        total_cnt++;
        if (steps != 3) $display("FAIL step_count: got %0d step cycles want 3", steps);
        else pass_cnt++;
        mode = 2'b00;
        for (int k = 0; k < 20; k++) begin
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL resume_phase: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int k;
        mode = 2'b10; step_req = 1'b1; cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd4;
        tick();
        step_req = 1'b0; cfg_we = 1'b0;
        total_cnt++;
        if (ce !== '1) $display("FAIL step_with_write: got ce=%b want all ones", ce);
        else pass_cnt++;
        mode = 2'b00;
        k = 0;
        while (((t_run[1] % (mdiv[1] + 1)) != mdiv[1]) && k < 20) begin
            tick();
            k++;
        end
        cfg_we = 1'b1; cfg_ch = 3'd1; cfg_div = 16'd2;
        tick();
        cfg_we = 1'b0;
        total_cnt++;
        if (ce[1] !== 1'b0 || ce !== m_ce) $display("FAIL write_vs_terminal: got ce=%b want ce=%b", ce, m_ce);
        else pass_cnt++;
        for (int j = 0; j < 8; j++) begin
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL after_collision: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
    endtask

    task automatic test_midop_reset();
        int n;
        int pulses;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        total_cnt++;
        if ({core_rst_n, lock_cnt, ce} !== '0)
            $display("FAIL midop_reset: got core=%b lock_cnt=%0d ce=%b want all zero", core_rst_n, lock_cnt, ce);
        else pass_cnt++;
        n = 0;
        do begin
            tick();
            n++;
        end while (core_rst_n !== 1'b1 && n < 40);
        total_cnt++;
        if (n != LOCK_CYCLES + 1) $display("FAIL midop_requal: got %0d cycles want %0d", n, LOCK_CYCLES + 1);
        else pass_cnt++;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            pulses += int'(ce[0]);
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL midop_run: got ce=%b want ce=%b", ce, m_ce);
            else pass_cnt++;
        end
        total_cnt++;
        if (pulses != 4) $display("FAIL midop_div_reset: got %0d ch0 pulses want 4", pulses);
        else pass_cnt++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            locked   = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
            step_req = ($urandom_range(0, 3) == 0);
            cfg_we   = ($urandom_range(0, 9) == 0);
            cfg_ch   = CH_W'($urandom);
            cfg_div  = DIV_W'($urandom_range(0, 12));
            tick();
            total_cnt++;
            if ({core_rst_n, lock_cnt, ce} !== {m_core, m_lock, m_ce})
                $display("FAIL random_cyc%0d: got core=%b lock_cnt=%0d ce=%b want core=%b lock_cnt=%0d ce=%b", k, core_rst_n, lock_cnt, ce, m_core, m_lock, m_ce);
            else pass_cnt++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lock();
        test_glitch();
        test_dividers();
        test_reconfig();
        test_halt_step();
        test_back_to_back();
        test_midop_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Parametrised clock-enable and reset sequencer between the PLL (`cpuclk`) and the CPU/BUS domain, replacing the plain `pll_clk & clk_lock` gating. It qualifies the PLL lock over a programmable number of cycles before releasing the core reset. It generates NUM_CH independently divided single-cycle clock enables on the one PLL clock, and adds a global halt/single-step debug mode.

## Interface
- NUM_CH, 4: number of clock-enable channels (1..16).
- DIV_W, 16: width of each channel divide register.
- LOCK_CYCLES, 16: consecutive locked cycles required before core reset release (>=1).
- DIV_RST, 0: divide value loaded into every channel at reset.
- clk  in  1  PLL output clock; the only clock.
- rst_n  in  1  synchronous, active-low reset.
- locked  in  1  PLL lock indicator, synchronous to clk.
- mode  in  2  00 RUN, 01 HALT, 10 STEP, 11 treated as HALT.
- step_req  in  1  single-cycle pulse; honoured only in STEP mode.
- cfg_we  in  1  divide-register write strobe.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write.
- cfg_div  in  DIV_W  new divide value D; channel period is D+1 cycles.
- core_rst_n  out  1  active-low reset to CPU and BUS.
- ce  out  NUM_CH  per-channel clock-enable pulses.
- lock_cnt  out  $clog2(LOCK_CYCLES+1)  current qualification count, for debug.

## Operation
- Top state machine:
  - WAIT_LOCK: core_rst_n=0, ce=0, channel counters held at 0.
  - Transition: lock_cnt increments each cycle locked=1 and saturates at LOCK_CYCLES. When lock_cnt==LOCK_CYCLES, enter ACTIVE.
  - ACTIVE: core_rst_n=1.
  - Any cycle with locked=0: lock_cnt←0, return to WAIT_LOCK, core_rst_n←0, ce←0, all channel counters←0. Divide registers are kept.
- Per channel i, in ACTIVE, effective mode RUN:
  - If cnt_i==div_i: ce_i←1, cnt_i←0.
  - Otherwise: ce_i←0, cnt_i←cnt_i+1.
  - D=0 gives ce high every cycle.
- HALT (mode 01 or 11): counters frozen, ce=0.
- STEP (mode 10):
  - Counters frozen.
  - A step_req cycle drives ce←all ones for exactly one cycle, regardless of div; counters are not modified.
  - step_req outside STEP mode is ignored.
- Mode is sampled every cycle. Leaving HALT/STEP for RUN resumes counting from the frozen counts.
- Config write:
  - cfg_we=1 with cfg_ch<NUM_CH: div←cfg_div and cnt←0 for that channel; ce for that channel ←0 that cycle.
  - cfg_ch≥NUM_CH: write ignored.
  - Writes are accepted in every state, including WAIT_LOCK.
- Counters are DIV_W bits; comparison is unsigned equality, so there is no overflow past div.

## Timing
- All outputs are registered.
- rst_n=0 at an edge sets the following, regardless of other inputs:
  - core_rst_n=0, ce=0, lock_cnt=0.
  - cnt=0 and div=DIV_RST for all channels.
  - State WAIT_LOCK.
- Reset asserted mid-operation takes effect at the next edge, identically.
- Lock qualification latency: locked rises before edge k; lock_cnt reaches LOCK_CYCLES after edge k+LOCK_CYCLES−1; core_rst_n=1 after edge k+LOCK_CYCLES.
- First ce_i after release: in RUN, ce_i=1 after edge k+LOCK_CYCLES+1+div_i (one-cycle pulse), then every div_i+1 cycles.
- Lock loss: locked=0 before edge j → core_rst_n=0 and ce=0 after edge j (one-cycle response).
- Write latency: cfg_we before edge j → new div used for the compare at edge j+1; next ce on that channel after edge j+1+D.
- Step: step_req before edge j in STEP mode → ce=all ones after edge j only.
- Simultaneous events, priority order:
  - rst_n over lock loss.
  - Lock loss over everything else.
  - cfg_we together with step_req: the write applies, and the step pulse still appears on all channels, including the written one.
  - cfg_we together with a terminal-count compare on the same channel: the write wins and no ce is produced.

## Test plan
- Reset/lock: LOCK_CYCLES=16, locked held 1 from cycle 3 → core_rst_n rises exactly 16 edges later; lock_cnt counts 1..16; ce=0 throughout.
- Lock glitch: locked drops for 1 cycle at count 10, then stays high → lock_cnt←0 and qualification restarts; release occurs 16 cycles after the glitch. A drop while ACTIVE clears core_rst_n and ce on the next edge.
- Dividers: div = {0,1,3,9} on ch0..3 in RUN → over 40 cycles ch0 pulses 40, ch1 20, ch2 10 and ch3 4 times. Pulses are exactly one cycle wide, with period D+1.
- Reconfig: ch2 running D=3, write D=7 at arbitrary phase → no ce the write cycle; next ce 8 cycles after the write, then period 8. A write to cfg_ch=NUM_CH changes nothing.
- Halt/step: switch RUN→HALT mid-count → ce=0 and counts frozen. STEP with 3 step_req pulses → exactly 3 all-ones ce cycles. Back to RUN → channels resume at the frozen phase.
- Mid-op reset: rst_n low for 1 cycle while ACTIVE → all outputs 0, div back to DIV_RST, and a full lock qualification is required again.
